// File: rtl/tlb_walk_arbiter_pkg.sv
// Shared MMU definitions for the TLB page-walk arbiter: FSM state codes,
// walk source encoding and the walk-result record passed from the walker
// back to the TLBs.
// Optional feature macro used by the arbiter: TLB_ARB_RR_EN.
package tlb_walk_arbiter_pkg;

    localparam int MMU_VPN_W = 20;
    localparam int MMU_PTE_W = 32;

    // FSM state encoding, kept as plain constants so older tools and
    // wave viewers see stable numeric codes.
    typedef logic [2:0] arb_state_t;
    localparam arb_state_t ST_IDLE  = 3'd0;
    localparam arb_state_t ST_ISSUE = 3'd1;
    localparam arb_state_t ST_WAIT  = 3'd2;
    localparam arb_state_t ST_RESP  = 3'd3;
    localparam arb_state_t ST_DRAIN = 3'd4;

    // Which TLB owns a walk.
    typedef enum logic {
        SRC_ITLB = 1'b0,
        SRC_DTLB = 1'b1
    } walk_src_e;

    // Result of one page walk.
    typedef struct packed {
        logic                 is_superpage;
        logic [MMU_PTE_W-1:0] pte;
        logic [3:0]           excp_code;
        logic                 excp_vld;
    } walk_res_t;

endpackage

// File: rtl/tlb_walk_arb_pick.sv
// Combinational grant selection between ITLB and DTLB miss requests.
// With TLB_ARB_RR_EN defined a one-bit pointer picks the winner when both
// request; it resets to favour the ITLB and toggles on every grant taken.
// Without it the DTLB always wins and no state exists.
module tlb_walk_arb_pick
    import tlb_walk_arbiter_pkg::*;
(
`ifdef TLB_ARB_RR_EN
    input  logic      cpu_clk_i,
    input  logic      cpu_rst_i,
    input  logic      adv_i,
`endif
    input  logic      itlb_vld_i,
    input  logic      dtlb_vld_i,
    output logic      grant_vld_o,
    output walk_src_e grant_src_o
);

`ifdef TLB_ARB_RR_EN
    walk_src_e ptr_q;
    walk_src_e ptr_d;

    // Pick the winner: the pointer breaks ties, a lone requester always wins.
    always_comb begin
        // NOTE: every combinational output gets a default first so no path
        // leaves it unassigned and a latch cannot be inferred.
        grant_vld_o = itlb_vld_i | dtlb_vld_i;
        grant_src_o = SRC_ITLB;
        ptr_d       = ptr_q;
        if (itlb_vld_i && dtlb_vld_i) begin
            grant_src_o = ptr_q;
        end else if (dtlb_vld_i) begin
            grant_src_o = SRC_DTLB;
        end
        if (adv_i) begin
            ptr_d = (ptr_q == SRC_ITLB) ? SRC_DTLB : SRC_ITLB;
        end
    end

    // Round-robin pointer; toggles each time the top takes a grant.
    always_ff @(posedge cpu_clk_i) begin
        if (cpu_rst_i) begin
            ptr_q <= SRC_ITLB;
        end else begin
            ptr_q <= ptr_d;
        end
    end
`else
    // Fixed priority: DTLB over ITLB.
    always_comb begin
        grant_vld_o = itlb_vld_i | dtlb_vld_i;
        grant_src_o = dtlb_vld_i ? SRC_DTLB : SRC_ITLB;
    end
`endif

endmodule

// File: rtl/tlb_walk_arbiter.sv
// Shares the single page walker between the ITLB and DTLB. One walk is
// owned at a time; the result is returned only to the owning TLB as a
// one-cycle pulse. A flush abandons the current walk, and a walk already
// accepted by the walker is drained and its result discarded.
// Optional feature macro: TLB_ARB_RR_EN (round-robin instead of fixed
// DTLB-over-ITLB priority). PTE_W must match MMU_PTE_W in the package.
module tlb_walk_arbiter
    import tlb_walk_arbiter_pkg::*;
#(
    parameter int VPN_W = MMU_VPN_W,
    parameter int PTE_W = MMU_PTE_W
) (
    input  logic             cpu_clk_i,
    input  logic             cpu_rst_i,
    input  logic             flush_i,
    // ITLB side
    input  logic [VPN_W-1:0] itlb_vpn_i,
    input  logic             itlb_vpn_vld_i,
    output logic             itlb_resp_vld_o,
    output logic             itlb_is_superpage_o,
    output logic [PTE_W-1:0] itlb_assoc_pte_o,
    output logic [3:0]       itlb_excp_code_o,
    output logic             itlb_excp_vld_o,
    // DTLB side
    input  logic [VPN_W-1:0] dtlb_vpn_i,
    input  logic             dtlb_vpn_vld_i,
    input  logic             dtlb_is_write_i,
    output logic             dtlb_resp_vld_o,
    output logic             dtlb_is_superpage_o,
    output logic [PTE_W-1:0] dtlb_assoc_pte_o,
    output logic [3:0]       dtlb_excp_code_o,
    output logic             dtlb_excp_vld_o,
    // Walker side
    output logic [VPN_W-1:0] walk_vpn_o,
    output logic             walk_is_write_o,
    output logic             walk_is_ifetch_o,
    output logic             walk_req_vld_o,
    input  logic             walk_req_rdy_i,
    input  logic             walk_resp_vld_i,
    input  logic             walk_is_superpage_i,
    input  logic [PTE_W-1:0] walk_pte_i,
    input  logic [3:0]       walk_excp_code_i,
    input  logic             walk_excp_vld_i,
    output logic             safe_to_flush_o
);

    arb_state_t state_q, state_d;
    walk_src_e  src_q;
    logic [VPN_W-1:0] vpn_q;
    logic       wr_q;
    walk_res_t  res_q;

    logic       grant_vld;
    walk_src_e  grant_src;
    logic       grant_take;
    logic       res_take;
    logic       resp_fire;
    logic       itlb_fire;
    logic       dtlb_fire;

    // A grant is taken only from IDLE, and never in a flush cycle.
    assign grant_take = (state_q == ST_IDLE) && !flush_i && grant_vld;
    // A result is kept only if no flush discards it in the same cycle.
    assign res_take   = (state_q == ST_WAIT) && !flush_i && walk_resp_vld_i;

    tlb_walk_arb_pick u_pick (
`ifdef TLB_ARB_RR_EN
        .cpu_clk_i   (cpu_clk_i),
        .cpu_rst_i   (cpu_rst_i),
        .adv_i       (grant_take),
`endif
        .itlb_vld_i  (itlb_vpn_vld_i),
        .dtlb_vld_i  (dtlb_vpn_vld_i),
        .grant_vld_o (grant_vld),
        .grant_src_o (grant_src)
    );

    // Next-state logic, including flush handling in every state.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (grant_take) state_d = ST_ISSUE;
            end
            ST_ISSUE: begin
                if (flush_i)             state_d = walk_req_rdy_i ? ST_DRAIN : ST_IDLE;
                else if (walk_req_rdy_i) state_d = ST_WAIT;
            end
            ST_WAIT: begin
                if (flush_i)              state_d = walk_resp_vld_i ? ST_IDLE : ST_DRAIN;
                else if (walk_resp_vld_i) state_d = ST_RESP;
            end
            ST_RESP: begin
                state_d = ST_IDLE;
            end
            ST_DRAIN: begin
                if (walk_resp_vld_i) state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State register with synchronous reset.
    always_ff @(posedge cpu_clk_i) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples pre-edge values regardless of block ordering.
        if (cpu_rst_i) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Latched request and result fields.
    always_ff @(posedge cpu_clk_i) begin
        // NOTE: these datapath registers carry no reset; every output they
        // feed is gated by the state register, which is reset.
        if (grant_take) begin
            src_q <= grant_src;
            vpn_q <= (grant_src == SRC_DTLB) ? dtlb_vpn_i : itlb_vpn_i;
            wr_q  <= (grant_src == SRC_DTLB) && dtlb_is_write_i;
        end
        if (res_take) begin
            res_q <= '{is_superpage: walk_is_superpage_i,
                       pte:          walk_pte_i,
                       excp_code:    walk_excp_code_i,
                       excp_vld:     walk_excp_vld_i};
        end
    end

    // Walker request side: driven only while issuing.
    always_comb begin
        walk_req_vld_o   = (state_q == ST_ISSUE);
        walk_vpn_o       = walk_req_vld_o ? vpn_q : '0;
        walk_is_write_o  = walk_req_vld_o && wr_q;
        walk_is_ifetch_o = walk_req_vld_o && (src_q == SRC_ITLB);
        safe_to_flush_o  = (state_q == ST_IDLE);
    end

    // Response routing: only the owner sees the pulse; a flush suppresses it.
    assign resp_fire = (state_q == ST_RESP) && !flush_i;
    assign itlb_fire = resp_fire && (src_q == SRC_ITLB);
    assign dtlb_fire = resp_fire && (src_q == SRC_DTLB);

    // Response fields: zero everywhere except on the owner's pulse.
    always_comb begin
        itlb_resp_vld_o     = itlb_fire;
        itlb_is_superpage_o = itlb_fire && res_q.is_superpage;
        itlb_assoc_pte_o    = itlb_fire ? res_q.pte : '0;
        itlb_excp_code_o    = itlb_fire ? res_q.excp_code : 4'd0;
        itlb_excp_vld_o     = itlb_fire && res_q.excp_vld;
        dtlb_resp_vld_o     = dtlb_fire;
        dtlb_is_superpage_o = dtlb_fire && res_q.is_superpage;
        dtlb_assoc_pte_o    = dtlb_fire ? res_q.pte : '0;
        dtlb_excp_code_o    = dtlb_fire ? res_q.excp_code : 4'd0;
        dtlb_excp_vld_o     = dtlb_fire && res_q.excp_vld;
    end

endmodule

// File: tb/tb_tlb_walk_arbiter.sv
// Self-checking bench for tlb_walk_arbiter. Expected responses are pushed
// to a scoreboard when the walker result is driven and popped when a TLB
// response pulse is seen. Build with or without TLB_ARB_RR_EN.
module tb_tlb_walk_arbiter;

    localparam int VPN_W = 20;
    localparam int PTE_W = 32;

    logic             cpu_clk_i = 1'b0;
    logic             cpu_rst_i;
    logic             flush_i;
    logic [VPN_W-1:0] itlb_vpn_i;
    logic             itlb_vpn_vld_i;
    logic             itlb_resp_vld_o;
    logic             itlb_is_superpage_o;
    logic [PTE_W-1:0] itlb_assoc_pte_o;
    logic [3:0]       itlb_excp_code_o;
    logic             itlb_excp_vld_o;
    logic [VPN_W-1:0] dtlb_vpn_i;
    logic             dtlb_vpn_vld_i;
    logic             dtlb_is_write_i;
    logic             dtlb_resp_vld_o;
    logic             dtlb_is_superpage_o;
    logic [PTE_W-1:0] dtlb_assoc_pte_o;
    logic [3:0]       dtlb_excp_code_o;
    logic             dtlb_excp_vld_o;
    logic [VPN_W-1:0] walk_vpn_o;
    logic             walk_is_write_o;
    logic             walk_is_ifetch_o;
    logic             walk_req_vld_o;
    logic             walk_req_rdy_i;
    logic             walk_resp_vld_i;
    logic             walk_is_superpage_i;
    logic [PTE_W-1:0] walk_pte_i;
    logic [3:0]       walk_excp_code_i;
    logic             walk_excp_vld_i;
    logic             safe_to_flush_o;

    tlb_walk_arbiter #(.VPN_W(VPN_W), .PTE_W(PTE_W)) dut (
        .cpu_clk_i           (cpu_clk_i),
        .cpu_rst_i           (cpu_rst_i),
        .flush_i             (flush_i),
        .itlb_vpn_i          (itlb_vpn_i),
        .itlb_vpn_vld_i      (itlb_vpn_vld_i),
        .itlb_resp_vld_o     (itlb_resp_vld_o),
        .itlb_is_superpage_o (itlb_is_superpage_o),
        .itlb_assoc_pte_o    (itlb_assoc_pte_o),
        .itlb_excp_code_o    (itlb_excp_code_o),
        .itlb_excp_vld_o     (itlb_excp_vld_o),
        .dtlb_vpn_i          (dtlb_vpn_i),
        .dtlb_vpn_vld_i      (dtlb_vpn_vld_i),
        .dtlb_is_write_i     (dtlb_is_write_i),
        .dtlb_resp_vld_o     (dtlb_resp_vld_o),
        .dtlb_is_superpage_o (dtlb_is_superpage_o),
        .dtlb_assoc_pte_o    (dtlb_assoc_pte_o),
        .dtlb_excp_code_o    (dtlb_excp_code_o),
        .dtlb_excp_vld_o     (dtlb_excp_vld_o),
        .walk_vpn_o          (walk_vpn_o),
        .walk_is_write_o     (walk_is_write_o),
        .walk_is_ifetch_o    (walk_is_ifetch_o),
        .walk_req_vld_o      (walk_req_vld_o),
        .walk_req_rdy_i      (walk_req_rdy_i),
        .walk_resp_vld_i     (walk_resp_vld_i),
        .walk_is_superpage_i (walk_is_superpage_i),
        .walk_pte_i          (walk_pte_i),
        .walk_excp_code_i    (walk_excp_code_i),
        .walk_excp_vld_i     (walk_excp_vld_i),
        .safe_to_flush_o     (safe_to_flush_o)
    );

    always #5 cpu_clk_i = ~cpu_clk_i;

    typedef struct {
        bit          is_dtlb;
        bit          sp;
        logic [31:0] pte;
        logic [3:0]  code;
        bit          ev;
    } exp_t;

    exp_t sb_q[$];
    int   n_checks = 0;
    int   n_errors = 0;

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Look at the response outputs and compare any pulse against the scoreboard.
    task automatic sample();
        exp_t e;
        if (itlb_resp_vld_o || dtlb_resp_vld_o) begin
            check("one_owner", {itlb_resp_vld_o, dtlb_resp_vld_o} == 2'b11, 0);
            if (sb_q.size() == 0) begin
                check("unexpected_resp", 1, 0);
            end else begin
                e = sb_q.pop_front();
                check("resp_owner", dtlb_resp_vld_o, e.is_dtlb);
                if (dtlb_resp_vld_o) begin
                    check("dtlb_resp", {dtlb_is_superpage_o, dtlb_assoc_pte_o, dtlb_excp_code_o, dtlb_excp_vld_o},
                          {e.sp, e.pte, e.code, e.ev});
                    check("itlb_quiet", {itlb_is_superpage_o, itlb_assoc_pte_o, itlb_excp_code_o, itlb_excp_vld_o}, 0);
                end else begin
                    check("itlb_resp", {itlb_is_superpage_o, itlb_assoc_pte_o, itlb_excp_code_o, itlb_excp_vld_o},
                          {e.sp, e.pte, e.code, e.ev});
                    check("dtlb_quiet", {dtlb_is_superpage_o, dtlb_assoc_pte_o, dtlb_excp_code_o, dtlb_excp_vld_o}, 0);
                end
            end
        end
    endtask

    // Advance one clock; inputs change and outputs are sampled on the falling edge.
    task automatic step();
        @(negedge cpu_clk_i);
        sample();
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_outs_zero"},
              {itlb_resp_vld_o, itlb_is_superpage_o, itlb_assoc_pte_o, itlb_excp_code_o, itlb_excp_vld_o,
               dtlb_resp_vld_o, dtlb_is_superpage_o, dtlb_assoc_pte_o, dtlb_excp_code_o, dtlb_excp_vld_o,
               walk_vpn_o, walk_is_write_o, walk_is_ifetch_o, walk_req_vld_o}, 0);
        check({tag, "_safe"}, safe_to_flush_o, 1);
    endtask

    task automatic apply_reset();
        cpu_rst_i = 1; flush_i = 0;
        itlb_vpn_i = '0; itlb_vpn_vld_i = 0;
        dtlb_vpn_i = '0; dtlb_vpn_vld_i = 0; dtlb_is_write_i = 0;
        walk_req_rdy_i = 0; walk_resp_vld_i = 0;
        walk_is_superpage_i = 0; walk_pte_i = '0; walk_excp_code_i = '0; walk_excp_vld_i = 0;
        step(); step();
        cpu_rst_i = 0;
    endtask

    // Step until the walker request appears, with a bounded budget.
    task automatic wait_req(input string tag, output int waited);
        waited = 0;
        while (!walk_req_vld_o && waited < 20) begin
            step();
            waited++;
        end
        check({tag, "_req_seen"}, walk_req_vld_o, 1);
    endtask

    // Run one full walk for an already-raised request and check it end to end.
    task automatic do_walk(input string tag, input bit exp_dtlb, input logic [19:0] exp_vpn, input bit exp_wr,
                           input int stall, input int lat, input bit sp, input logic [31:0] pte,
                           input logic [3:0] code, input bit ev, output int waited);
        exp_t e;
        wait_req(tag, waited);
        if (!walk_req_vld_o) return;
        check({tag, "_vpn"}, walk_vpn_o, exp_vpn);
        check({tag, "_wr"}, walk_is_write_o, exp_wr);
        check({tag, "_ifetch"}, walk_is_ifetch_o, !exp_dtlb);
        for (int i = 0; i < stall; i++) begin
            step();
            check({tag, "_hold"}, {walk_req_vld_o, walk_vpn_o}, {1'b1, exp_vpn});
        end
        walk_req_rdy_i = 1;
        step();
        walk_req_rdy_i = 0;
        check({tag, "_req_drop"}, walk_req_vld_o, 0);
        for (int i = 1; i < lat; i++) step();
        walk_resp_vld_i = 1; walk_is_superpage_i = sp; walk_pte_i = pte;
        walk_excp_code_i = code; walk_excp_vld_i = ev;
        e.is_dtlb = exp_dtlb; e.sp = sp; e.pte = pte; e.code = code; e.ev = ev;
        sb_q.push_back(e);
        step();
        walk_resp_vld_i = 0; walk_is_superpage_i = 0; walk_pte_i = '0;
        walk_excp_code_i = '0; walk_excp_vld_i = 0;
        check({tag, "_pulse_next"}, sb_q.size(), 0);
        if (exp_dtlb) dtlb_vpn_vld_i = 0;
        else          itlb_vpn_vld_i = 0;
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: bench did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        int w;

        // Reset state
        apply_reset();
        check_reset_outputs("reset");

        // ITLB-only walk, request visible one cycle after it is raised
        itlb_vpn_i = 20'h12345; itlb_vpn_vld_i = 1;
        do_walk("itlb", 0, 20'h12345, 0, 0, 3, 0, 32'h0ABCD0CF, 4'd0, 0, w);
        check("itlb_latency", w, 1);
        step();
        check("itlb_back_idle", safe_to_flush_o, 1);

        // Both TLBs request in the same cycle, from a fresh reset
        apply_reset();
        itlb_vpn_i = 20'h00111; itlb_vpn_vld_i = 1;
        dtlb_vpn_i = 20'h00222; dtlb_vpn_vld_i = 1;
`ifdef TLB_ARB_RR_EN
        do_walk("dual_a", 0, 20'h00111, 0, 0, 2, 1, 32'h11110001, 4'd0, 0, w);
        do_walk("dual_b", 1, 20'h00222, 0, 0, 2, 0, 32'h22220002, 4'd0, 0, w);
`else
        do_walk("dual_a", 1, 20'h00222, 0, 0, 2, 1, 32'h22220002, 4'd0, 0, w);
        do_walk("dual_b", 0, 20'h00111, 0, 0, 2, 0, 32'h11110001, 4'd0, 0, w);
`endif
        check("dual_turnaround", w, 2);
        step();

        // DTLB store walk with a fault; walker stalls two cycles before accepting
        dtlb_vpn_i = 20'h0ABCD; dtlb_is_write_i = 1; dtlb_vpn_vld_i = 1;
        do_walk("dstore", 1, 20'h0ABCD, 1, 2, 1, 0, 32'h0, 4'd15, 1, w);
        dtlb_is_write_i = 0;
        step();

        // Flush while waiting for the walker: drain and discard
        itlb_vpn_i = 20'h00F0F; itlb_vpn_vld_i = 1;
        wait_req("fl_wait", w);
        walk_req_rdy_i = 1;
        step();
        walk_req_rdy_i = 0;
        flush_i = 1; itlb_vpn_vld_i = 0;
        step();
        flush_i = 0;
        check("fl_wait_drain", {safe_to_flush_o, walk_req_vld_o}, 2'b00);
        for (int i = 0; i < 3; i++) begin
            step();
            check("fl_wait_busy", safe_to_flush_o, 0);
        end
        walk_resp_vld_i = 1; walk_pte_i = 32'hDEADBEEF;
        step();
        walk_resp_vld_i = 0; walk_pte_i = '0;
        check("fl_wait_safe", safe_to_flush_o, 1);
        check("fl_wait_nopulse", {itlb_resp_vld_o, dtlb_resp_vld_o}, 0);
        step();
        check("fl_wait_nopulse2", {itlb_resp_vld_o, dtlb_resp_vld_o}, 0);

        // Flush in the same cycle as the issue handshake: DRAIN, not IDLE
        dtlb_vpn_i = 20'h00777; dtlb_vpn_vld_i = 1;
        wait_req("fl_hs", w);
        walk_req_rdy_i = 1; flush_i = 1; dtlb_vpn_vld_i = 0;
        step();
        walk_req_rdy_i = 0; flush_i = 0;
        check("fl_hs_drain", {safe_to_flush_o, walk_req_vld_o}, 2'b00);
        walk_resp_vld_i = 1; walk_pte_i = 32'h12121212;
        step();
        walk_resp_vld_i = 0; walk_pte_i = '0;
        check("fl_hs_safe", safe_to_flush_o, 1);
        check("fl_hs_nopulse", {itlb_resp_vld_o, dtlb_resp_vld_o}, 0);

        // Flush in ISSUE with the walker not ready: straight back to IDLE
        itlb_vpn_i = 20'h00888; itlb_vpn_vld_i = 1;
        wait_req("fl_issue", w);
        flush_i = 1; itlb_vpn_vld_i = 0;
        step();
        flush_i = 0;
        check("fl_issue_idle", {safe_to_flush_o, walk_req_vld_o}, 2'b10);

        // Reset in the middle of WAIT; a late walker response is ignored
        itlb_vpn_i = 20'h00999; itlb_vpn_vld_i = 1;
        wait_req("rst_wait", w);
        walk_req_rdy_i = 1;
        step();
        walk_req_rdy_i = 0;
        check("rst_wait_busy", safe_to_flush_o, 0);
        cpu_rst_i = 1; itlb_vpn_vld_i = 0;
        step();
        cpu_rst_i = 0;
        check_reset_outputs("rst_wait");
        walk_resp_vld_i = 1; walk_pte_i = 32'h55AA55AA;
        step();
        walk_resp_vld_i = 0; walk_pte_i = '0;
        check_reset_outputs("rst_late");
        step();
        check_reset_outputs("rst_late2");

        check("sb_empty", sb_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
